// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic units.
package serial_arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: two half-subtractor stages whose borrows are ORed.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d_s;
  logic hs1_b_s;
  logic hs2_b_s;

  assign hs1_d_s = x ^ y;
  assign hs1_b_s = ~x & y;
  assign d       = hs1_d_s ^ bin;
  assign hs2_b_s = ~hs1_d_s & bin;
  assign bout    = hs1_b_s | hs2_b_s;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b, one bit per clock through a
// single full-subtractor cell with a registered borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;

  logic             d_s;
  logic             br_next_s;
  logic [WIDTH-1:0] res_next_s;

  full_subtractor u_fs (
    .x    (a_sh_r[0]),
    .y    (b_sh_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (br_next_s)
  );

  assign res_next_s = {d_s, res_sh_r[WIDTH-1:1]};

  assign busy = (state_r == SHIFT);
  assign done = (state_r == DONE);

  // Control FSM, operand/result shifters, bit counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      res_sh_r   <= '0;
      cnt_r      <= '0;
      br_r       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            br_r     <= 1'b0;
            cnt_r    <= '0;
            res_sh_r <= '0;
            state_r  <= SHIFT;
          end else begin
            state_r  <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= res_next_s;
          br_r     <= br_next_s;
          // The counter holds on the last bit so it never wraps for power-of-two widths
          if (cnt_r == LAST_CNT) begin
            diff       <= res_next_s;
            borrow_out <= br_next_s;
            state_r    <= DONE;
          end else begin
            cnt_r      <= cnt_r + CW'(1);
            state_r    <= SHIFT;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
